// File: rtl/chk_testdata.sv
// chk_testdata: incrementing-pattern stream checker; CHK_TESTDATA_BACKPRESSURE_EN adds LFSR-throttled ready_out
module chk_testdata #(
  parameter int DATA_W = 32,
  parameter int SAMPLE_CNT_MAX = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              last_in,
  output logic              ready_out,
  output logic              locked,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       word_err_cnt,
  output logic [15:0]       len_err_cnt,
  output logic              frame_done,
  output logic              err_pulse
);
  localparam logic [15:0] LAST_IDX = 16'(SAMPLE_CNT_MAX - 1);
  typedef enum logic {SEEK, TRACK} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] exp_data;
  logic [15:0] idx;
  logic idx_sat, accept, at_end, word_err, len_err;
  assign accept = valid_in & ready_out;
  assign at_end = idx == LAST_IDX;
`ifdef CHK_TESTDATA_BACKPRESSURE_EN
  logic [7:0] lfsr;
  // free-running Fibonacci LFSR (taps 8,6,5,4) throttles ready to roughly 75 %
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr <= 8'hA5;
      ready_out <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      ready_out <= lfsr[1] | lfsr[0];
    end
`else
  // always ready once out of reset
  always_ff @(posedge clk or posedge rst)
    if (rst) ready_out <= 1'b0;
    else ready_out <= 1'b1;
`endif
  // tracker state register; SEEK is only re-entered through reset
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SEEK;
    else state <= state_nx;
  // next state and per-beat error classification
  always_comb begin
    state_nx = state;
    word_err = 1'b0;
    len_err = 1'b0;
    if (accept) begin
      state_nx = TRACK;
      word_err = state == TRACK && data_in != exp_data;
      len_err = last_in ? !at_end : at_end && !idx_sat;
    end
  end
  // sequence/index tracking, saturating counters and event pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exp_data <= '0;
      idx <= '0;
      idx_sat <= 1'b0;
      locked <= 1'b0;
      frame_cnt <= '0;
      word_err_cnt <= '0;
      len_err_cnt <= '0;
      frame_done <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      frame_done <= accept & last_in;
      err_pulse <= word_err | len_err;
      if (word_err && word_err_cnt != 16'hFFFF) word_err_cnt <= word_err_cnt + 16'd1;
      if (len_err && len_err_cnt != 16'hFFFF) len_err_cnt <= len_err_cnt + 16'd1;
      if (accept) begin
        exp_data <= data_in + DATA_W'(1);
        locked <= 1'b1;
        idx <= last_in ? 16'd0 : at_end ? idx : idx + 16'd1;
        idx_sat <= !last_in && (idx_sat || at_end);
        frame_cnt <= frame_cnt + 32'(last_in);
      end
    end
endmodule

// File: tb/tb_chk_testdata.sv
// tb_chk_testdata: randomized and directed checks of chk_testdata against a frame-level reference model
module tb_chk_testdata;
  localparam int N = 100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] data_in = '0;
  logic valid_in = 1'b0;
  logic last_in = 1'b0;
  logic ready_out, locked, frame_done, err_pulse;
  logic [31:0] frame_cnt;
  logic [15:0] word_err_cnt, len_err_cnt;
  int checks = 0;
  int errors = 0;
  bit m_have;
  logic [31:0] m_prev;
  int m_pos;
  int m_frames, m_werr, m_lerr;
  bit m_fd, m_ep;
  bit saw_not_ready = 1'b0;

  chk_testdata #(.DATA_W(32), .SAMPLE_CNT_MAX(N)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .last_in(last_in),
    .ready_out(ready_out), .locked(locked), .frame_cnt(frame_cnt), .word_err_cnt(word_err_cnt),
    .len_err_cnt(len_err_cnt), .frame_done(frame_done), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_prev = '0; m_pos = 0;
    m_frames = 0; m_werr = 0; m_lerr = 0;
  endtask

  // frame-level view: a word must follow its predecessor by one; m_pos counts words since frame start
  task automatic model_beat(input logic [31:0] d, input bit l);
    bit we, le;
    we = m_have && d != m_prev + 32'd1;
    le = l ? (m_pos < N - 1) : (m_pos == N - 1);
    m_have = 1; m_prev = d;
    m_pos = l ? 0 : m_pos + 1;
    if (l) m_frames++;
    if (we) m_werr++;
    if (le) m_lerr++;
    m_fd = l; m_ep = we | le;
  endtask

  // called #1 after a posedge; holds the beat until accepted
  task automatic send(input logic [31:0] d, input bit l);
    bit acc = 0;
    data_in = d; last_in = l; valid_in = 1'b1;
    for (int w = 0; w < 64 && !acc; w++) begin
      acc = ready_out;
      if (!acc) saw_not_ready = 1'b1;
      if (acc) model_beat(d, l);
      @(posedge clk); #1;
      check("frame_done", 32'(frame_done), acc ? 32'(m_fd) : 32'd0);
      check("err_pulse", 32'(err_pulse), acc ? 32'(m_ep) : 32'd0);
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check("idle_pulses", {30'd0, frame_done, err_pulse}, 32'd0);
    end
  endtask

  task automatic counts(input string tag);
    check({tag, "_frames"}, frame_cnt, 32'(m_frames));
    check({tag, "_werr"}, 32'(word_err_cnt), 32'(m_werr));
    check({tag, "_lerr"}, 32'(len_err_cnt), 32'(m_lerr));
    check({tag, "_locked"}, 32'(locked), 32'(m_have));
  endtask

  task automatic do_reset();
    rst = 1'b1; #1;
    check("rst_frames", frame_cnt, 32'd0);
    check("rst_cnts", {word_err_cnt, len_err_cnt}, 32'd0);
    check("rst_flags", {28'd0, ready_out, locked, frame_done, err_pulse}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] v, d;
    int flen, pos;
    bit l;
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("reset_frames", frame_cnt, 32'd0);
    check("reset_flags", {28'd0, ready_out, locked, frame_done, err_pulse}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // clean stream, 3 frames
    for (int i = 0; i < 300; i++) begin
      send(32'(i), i % N == N - 1);
      if (i == 0) check("locked_first", 32'(locked), 32'd1);
    end
    counts("clean");
    check("clean_frames_const", frame_cnt, 32'd3);
    check("clean_err_const", {word_err_cnt, len_err_cnt}, 32'd0);
`ifdef CHK_TESTDATA_BACKPRESSURE_EN
    check("saw_backpressure", 32'(saw_not_ready), 32'd1);
`endif
    // sequence glitch
    do_reset();
    for (int i = 0; i < N; i++) send(i == 50 ? 32'hDEAD : 32'(i), i == N - 1);
    counts("glitch");
    check("glitch_werr_const", 32'(word_err_cnt), 32'd2);
    // wrap across all-ones
    do_reset();
    for (int i = 0; i < N; i++) send(32'hFFFF_FFFE + 32'(i), i == N - 1);
    counts("wrap");
    check("wrap_werr_const", 32'(word_err_cnt), 32'd0);
    // short frame then full frame
    do_reset();
    for (int i = 0; i < 50; i++) send(32'(i), i == 49);
    for (int i = 0; i < N; i++) send(32'(50 + i), i == N - 1);
    counts("short");
    check("short_lerr_const", 32'(len_err_cnt), 32'd1);
    check("short_frames_const", frame_cnt, 32'd2);
    // missing last, frame of 150
    do_reset();
    for (int i = 0; i < 150; i++) send(32'(i), i == 149);
    counts("long");
    check("long_lerr_const", 32'(len_err_cnt), 32'd1);
    check("long_frames_const", frame_cnt, 32'd1);
    // reset mid-frame then a fresh stream
    do_reset();
    for (int i = 0; i <= 30; i++) send(32'(i), 1'b0);
    do_reset();
    idle(2);
    for (int i = 0; i < N; i++) send(32'(1000 + i), i == N - 1);
    counts("rstmid");
    check("rstmid_err_const", {word_err_cnt, len_err_cnt}, 32'd0);
    // random stream: occasional glitches, random frame lengths, idle gaps
    do_reset();
    v = $urandom; flen = N; pos = 0;
    for (int k = 0; k < 600; k++) begin
      d = ($urandom_range(0, 19) == 0) ? 32'($urandom) : v;
      l = pos == flen - 1;
      send(d, l);
      v = d + 32'd1;
      pos = l ? 0 : pos + 1;
      if (l) flen = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 150)) : N;
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      if (k % 150 == 149) counts("rand");
    end
    counts("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
